hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Producer-side complement of forwarding_unit. Shadows in-flight destinations (EX/MEM/WB) and stalls
//   Decode when a source operand cannot be forwarded in time (load-use, branch-in-ID, memory busy).
// - Sits beside the control unit. Drives pipeline-register enables and the EX bubble; forwarding_unit
//   then resolves every hazard this block lets through.
// PARAMETERS
// - CNT_WIDTH    16   width of saturating stall-cycle counter
// - MDU_LATENCY  32   EX cycles of a mul/div op (used only with MDU_STALL_EN)
// PORTS
// - clock          in   1   system clock
// - reset          in   1   synchronous, active-high
// - id_valid       in   1   instruction present in ID
// - id_rd          in   5   ID destination register
// - id_reg_we      in   1   ID writes rd
// - id_load        in   1   ID is a load
// - id_zicsr       in   1   ID is a CSR op (result available in EX)
// - id_mdu         in   1   ID is a mul/div op
// - id_fwd_type    in   2   forwarding_type_t of ID (NoType/Type1/Type2/Type1_3)
// - rs1_id, rs2_id in   5   ID source registers
// - flush_id       in   1   ID squashed (taken branch/trap)
// - mem_busy       in   1   data memory has not acked the MEM access
// - stall_if       out  1   hold PC and IF/ID register
// - stall_id       out  1   hold ID
// - bubble_ex      out  1   load NOP into ID/EX
// - stall_ex       out  1   hold ID/EX register
// - stall_mem      out  1   hold EX/MEM and MEM/WB registers
// - stall_cnt      out  CNT_WIDTH  cycles with stall_id=1, saturating
// BEHAVIOUR
// - Shadow regs ex_q, mem_q, wb_q = {valid, rd, reg_we, load, zicsr}. Reset: all valid=0.
//   All outputs 0 after reset. stall_cnt = 0.
// - match(rs,e) = e.valid & e.reg_we & (e.rd != 0) & (rs == e.rd). rs2 is used only if
//   id_fwd_type != NoType.
// - load_use: match(rs1|rs2, ex_q) & ex_q.load.
// - br_hz (Type2 only): rs1 matches ex_q with !ex_q.zicsr; or rs1/rs2 matches ex_q on rs2;
//   or rs1/rs2 matches mem_q & mem_q.load.
// - hz = id_valid & !flush_id & (load_use | br_hz). Combinational outputs:
//   stall_if = stall_id = hz | mem_busy | mdu_busy.
//   bubble_ex = hz & !mem_busy & !mdu_busy.
//   stall_ex = mem_busy | mdu_busy.
//   stall_mem = mem_busy.
// - Per-clock update, priority order:
//   - mem_busy: all shadow regs hold.
//   - else mdu_busy: ex_q holds; mem_q <= bubble; wb_q <= mem_q.
//   - else: wb_q <= mem_q; mem_q <= ex_q; ex_q <= bubble if (hz | flush_id | !id_valid),
//     else the ID fields.
// - Latency: a load stalls a dependent ID instruction exactly 1 cycle. A Type2 dependent on a load
//   stalls 2 cycles; on an ALU op, 1 cycle.
// - Simultaneous flush_id & hz: flush wins, no stall, ex_q <= bubble.
// - mem_busy mid-stall: hz remains asserted; the bubble is inserted only when mem_busy drops.
// - stall_cnt increments when stall_id=1 and saturates at all-ones (no wrap).
// - reset mid-stall: next cycle all shadow entries are invalid and the stall is released.
// CONFIGURATION
// - MDU_STALL_EN defined: an ex_q entry with mdu=1 loads a down-counter with MDU_LATENCY-1 on entry.
//   mdu_busy = (cnt != 0). The counter clears on reset and freezes while mem_busy.
// - MDU_STALL_EN undefined: mdu_busy tied 0, id_mdu ignored, counter logic absent.
// TESTING
// - lw x5 in EX; ID add x6,x5,x1 (Type1) -> stall_id=1, bubble_ex=1 for 1 cycle, then released.
// - ALU op writes x7 in EX; ID beq x7,x0 (Type2) -> 1 stall cycle; lw x7 in EX -> 2 stall cycles.
// - rd=x0 load in EX; ID reads x0 -> no stall; stall_cnt unchanged.
// - load-use plus mem_busy held 3 cycles -> stall_mem=1 for 3 cycles; bubble_ex=1 only in cycle 4.
// - flush_id with load-use pending -> stall_id=0, ex_q invalid; 70000 stalls -> stall_cnt=16'hFFFF.
// - MDU_STALL_EN, MDU_LATENCY=4: div enters EX -> stall_ex=1 for 3 cycles; reset in cycle 2 -> outputs 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Interface bundling the decode-side hazard inputs and the pipeline
// stall/bubble controls exchanged between the control path and
// hazard_scoreboard. The master modport belongs to the control/decode side,
// and the slave modport belongs to the scoreboard itself.
interface hazard_scoreboard_if #(
    parameter int CNT_WIDTH = 16
);
    // Instruction currently in ID
    logic                 id_valid;
    logic [4:0]           id_rd;
    logic                 id_reg_we;
    logic                 id_load;
    logic                 id_zicsr;
    logic                 id_mdu;
    logic [1:0]           id_fwd_type;
    logic [4:0]           rs1_id;
    logic [4:0]           rs2_id;

    // Pipeline events
    logic                 flush_id;
    logic                 mem_busy;

    // Pipeline-register controls
    logic                 stall_if;
    logic                 stall_id;
    logic                 bubble_ex;
    logic                 stall_ex;
    logic                 stall_mem;
    logic [CNT_WIDTH-1:0] stall_cnt;

    modport master (
        output id_valid, id_rd, id_reg_we, id_load, id_zicsr, id_mdu,
               id_fwd_type, rs1_id, rs2_id, flush_id, mem_busy,
        input  stall_if, stall_id, bubble_ex, stall_ex, stall_mem, stall_cnt
    );

    modport slave (
        input  id_valid, id_rd, id_reg_we, id_load, id_zicsr, id_mdu,
               id_fwd_type, rs1_id, rs2_id, flush_id, mem_busy,
        output stall_if, stall_id, bubble_ex, stall_ex, stall_mem, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadows the destinations of the instructions in
// EX/MEM/WB. It stalls Decode whenever a source operand cannot be forwarded
// in time: load-use, a branch resolved in ID, or a busy data memory.
// Optional feature: define MDU_STALL_EN to hold EX for MDU_LATENCY cycles
// behind a mul/div op. Without the macro, id_mdu is ignored and no counter
// is built.
module hazard_scoreboard #(
    parameter int CNT_WIDTH   = 16,
    parameter int MDU_LATENCY = 32
) (
    input  logic                clock,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    typedef enum logic [1:0] {
        FWD_NONE    = 2'd0,
        FWD_TYPE1   = 2'd1,
        FWD_TYPE2   = 2'd2,
        FWD_TYPE1_3 = 2'd3
    } fwd_type_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_we;
        logic       load;
        logic       zicsr;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    shadow_t ex_q;
    shadow_t mem_q;
    shadow_t wb_q;
    shadow_t id_entry;

    logic rs2_used;
    logic is_type2;
    logic m1_ex;
    logic m2_ex;
    logic m1_mem;
    logic m2_mem;
    logic load_use;
    logic br_hz;
    logic hz;
    logic ex_capture;
    logic mdu_busy;
    logic stall;

    logic [CNT_WIDTH-1:0] stall_cnt_q;

    // A producer only matters if it is valid, writes a register and is not x0
    function automatic logic match(input logic [4:0] rs, input shadow_t e);
        return e.valid & e.reg_we & (e.rd != 5'd0) & (rs == e.rd);
    endfunction

    assign id_entry = '{valid:  bus.id_valid,
                        rd:     bus.id_rd,
                        reg_we: bus.id_reg_we,
                        load:   bus.id_load,
                        zicsr:  bus.id_zicsr};

    // Hazard detection against the EX and MEM shadows
    always_comb begin
        rs2_used = 1'b0;
        is_type2 = 1'b0;
        m1_ex    = 1'b0;
        m2_ex    = 1'b0;
        m1_mem   = 1'b0;
        m2_mem   = 1'b0;
        load_use = 1'b0;
        br_hz    = 1'b0;
        hz       = 1'b0;

        rs2_used = (bus.id_fwd_type != FWD_NONE);
        is_type2 = (bus.id_fwd_type == FWD_TYPE2);

        m1_ex  = match(bus.rs1_id, ex_q);
        m2_ex  = rs2_used & match(bus.rs2_id, ex_q);
        m1_mem = match(bus.rs1_id, mem_q);
        m2_mem = rs2_used & match(bus.rs2_id, mem_q);

        load_use = (m1_ex | m2_ex) & ex_q.load;

        // A branch compares in ID, so only a CSR result on rs1 is early enough
        br_hz = is_type2 & ((m1_ex & ~ex_q.zicsr) | m2_ex |
                            ((m1_mem | m2_mem) & mem_q.load));

        hz = bus.id_valid & ~bus.flush_id & (load_use | br_hz);
    end

    assign ex_capture = ~(hz | bus.flush_id | ~bus.id_valid);
    assign stall      = hz | bus.mem_busy | mdu_busy;

    assign bus.stall_if  = stall;
    assign bus.stall_id  = stall;
    assign bus.bubble_ex = hz & ~bus.mem_busy & ~mdu_busy;
    assign bus.stall_ex  = bus.mem_busy | mdu_busy;
    assign bus.stall_mem = bus.mem_busy;
    assign bus.stall_cnt = stall_cnt_q;

    // Shadow pipeline advance: memory stall freezes all, MDU stall drains behind EX
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else if (bus.mem_busy) begin
            ex_q  <= ex_q;
            mem_q <= mem_q;
            wb_q  <= wb_q;
        end else if (mdu_busy) begin
            ex_q  <= ex_q;
            mem_q <= BUBBLE;
            wb_q  <= mem_q;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_capture ? id_entry : BUBBLE;
        end
    end

    // Saturating count of cycles in which Decode was held
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

`ifdef MDU_STALL_EN
    localparam int MDU_CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

    logic [MDU_CW-1:0] mdu_cnt;

    // Down-counter armed when a mul/div enters EX; frozen while memory is busy
    always_ff @(posedge clock) begin
        if (reset) begin
            mdu_cnt <= '0;
        end else if (!bus.mem_busy) begin
            if (mdu_cnt != '0) begin
                mdu_cnt <= mdu_cnt - 1'b1;
            end else if (ex_capture && bus.id_mdu) begin
                mdu_cnt <= MDU_CW'(MDU_LATENCY - 1);
            end
        end
    end

    assign mdu_busy = (mdu_cnt != '0);
`else
    logic mdu_unused;

    assign mdu_busy   = 1'b0;
    assign mdu_unused = bus.id_mdu ^ (MDU_LATENCY > 1);
`endif

    // WB is tracked only so the shadow mirrors the real pipeline depth
    logic wb_unused;
    assign wb_unused = ^wb_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a
// randomized run against a distance-based reference model of operand
// readiness.
module tb_hazard_scoreboard;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    hazard_scoreboard_if #(.CNT_WIDTH(16)) bus ();

    hazard_scoreboard #(.CNT_WIDTH(16), .MDU_LATENCY(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: producers by distance from ID (index 0 = one stage ahead)
    typedef struct {
        bit valid;
        int rd;
        bit we;
        bit load;
        bit zicsr;
    } ent_t;

    ent_t m_pipe[3];
    int   m_cnt;

    function automatic ent_t make_ent(bit v, int rd, bit we, bit ld, bit cs);
        ent_t e;
        e.valid = v;
        e.rd    = rd;
        e.we    = we;
        e.load  = ld;
        e.zicsr = cs;
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = make_ent(0, 0, 0, 0, 0);
        m_cnt = 0;
    endfunction

    // Minimum distance at which a producer's result can reach this operand
    function automatic int need_dist(ent_t e, int fwd, bit is_rs1);
        if (fwd == 2) begin
            if (e.load) return 3;
            if (is_rs1 && e.zicsr) return 1;
            return 2;
        end
        if (e.load) return 2;
        return 1;
    endfunction

    function automatic bit model_hazard(bit v, bit fl, int fwd, int rs1, int rs2);
        bit dep = 0;
        if (!v || fl) return 0;
        for (int d = 0; d < 3; d++) begin
            if (m_pipe[d].valid && m_pipe[d].we && m_pipe[d].rd != 0) begin
                if (rs1 == m_pipe[d].rd && (d + 1) < need_dist(m_pipe[d], fwd, 1)) dep = 1;
                if (fwd != 0 && rs2 == m_pipe[d].rd && (d + 1) < need_dist(m_pipe[d], fwd, 0)) dep = 1;
            end
        end
        return dep;
    endfunction

    function automatic logic [4:0] outs();
        return {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.stall_ex, bus.stall_mem};
    endfunction

    task automatic set_id(bit v, int rd, bit we, bit ld, bit cs, int fwd, int rs1, int rs2);
        bus.id_valid    = v;
        bus.id_rd       = 5'(rd);
        bus.id_reg_we   = we;
        bus.id_load     = ld;
        bus.id_zicsr    = cs;
        bus.id_mdu      = 1'b0;
        bus.id_fwd_type = 2'(fwd);
        bus.rs1_id      = 5'(rs1);
        bus.rs2_id      = 5'(rs2);
    endtask

    task automatic set_ctl(bit fl, bit mb);
        bus.flush_id = fl;
        bus.mem_busy = mb;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_id(1, 6, 1, 0, 0, 2, 5, 5);
        set_ctl(0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL reset_outs: got %b want %b", outs(), 5'b00000); end
        checks++;
        if (bus.stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", bus.stall_cnt); end
        @(negedge clock);
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 5, 1, 1, 0, 1, 2, 3);
        @(negedge clock);
        set_id(1, 6, 1, 0, 0, 1, 5, 1);
        #1;
        checks++;
        if (outs() !== 5'b11100) begin errors++; $display("[TB] FAIL load_use_stall: got %b want %b", outs(), 5'b11100); end
        @(negedge clock);
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL load_use_release: got %b want %b", outs(), 5'b00000); end
        @(negedge clock);
    endtask

    task automatic test_branch();
        do_reset();
        set_id(1, 7, 1, 0, 0, 1, 1, 2);
        @(negedge clock);
        set_id(1, 0, 0, 0, 0, 2, 7, 0);
        #1;
        checks++;
        if (outs() !== 5'b11100) begin errors++; $display("[TB] FAIL branch_alu_c1: got %b want %b", outs(), 5'b11100); end
        @(negedge clock);
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL branch_alu_c2: got %b want %b", outs(), 5'b00000); end
        do_reset();
        set_id(1, 7, 1, 1, 0, 1, 1, 2);
        @(negedge clock);
        set_id(1, 0, 0, 0, 0, 2, 7, 0);
        #1;
        checks++;
        if (outs() !== 5'b11100) begin errors++; $display("[TB] FAIL branch_load_c1: got %b want %b", outs(), 5'b11100); end
        @(negedge clock);
        #1;
        checks++;
        if (outs() !== 5'b11100) begin errors++; $display("[TB] FAIL branch_load_c2: got %b want %b", outs(), 5'b11100); end
        @(negedge clock);
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL branch_load_c3: got %b want %b", outs(), 5'b00000); end
        @(negedge clock);
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1, 0, 1, 1, 0, 1, 1, 2);
        @(negedge clock);
        set_id(1, 6, 1, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL x0_no_stall: got %b want %b", outs(), 5'b00000); end
        @(negedge clock);
        #1;
        checks++;
        if (bus.stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL x0_cnt: got %0d want 0", bus.stall_cnt); end
        @(negedge clock);
    endtask

    task automatic test_mem_busy();
        do_reset();
        set_id(1, 5, 1, 1, 0, 1, 2, 3);
        @(negedge clock);
        set_id(1, 6, 1, 0, 0, 3, 1, 5);
        set_ctl(0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs() !== 5'b11011) begin errors++; $display("[TB] FAIL mem_busy_c%0d: got %b want %b", i + 1, outs(), 5'b11011); end
            @(negedge clock);
        end
        set_ctl(0, 0);
        #1;
        checks++;
        if (outs() !== 5'b11100) begin errors++; $display("[TB] FAIL mem_busy_bubble: got %b want %b", outs(), 5'b11100); end
        @(negedge clock);
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL mem_busy_release: got %b want %b", outs(), 5'b00000); end
        checks++;
        if (bus.stall_cnt !== 16'd4) begin errors++; $display("[TB] FAIL mem_busy_cnt: got %0d want 4", bus.stall_cnt); end
        @(negedge clock);
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 5, 1, 1, 0, 1, 2, 3);
        @(negedge clock);
        set_id(1, 9, 1, 1, 0, 1, 5, 5);
        set_ctl(1, 0);
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL flush_wins: got %b want %b", outs(), 5'b00000); end
        @(negedge clock);
        set_id(1, 6, 1, 0, 0, 1, 9, 9);
        set_ctl(0, 0);
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL flush_ex_invalid: got %b want %b", outs(), 5'b00000); end
        checks++;
        if (bus.stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL flush_cnt: got %0d want 0", bus.stall_cnt); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 5, 1, 1, 0, 1, 2, 3);
        @(negedge clock);
        set_id(1, 6, 1, 0, 0, 1, 5, 1);
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 5'b11100) begin errors++; $display("[TB] FAIL rst_mid_before: got %b want %b", outs(), 5'b11100); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== 5'b00000) begin errors++; $display("[TB] FAIL rst_mid_release: got %b want %b", outs(), 5'b00000); end
        checks++;
        if (bus.stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_cnt: got %0d want 0", bus.stall_cnt); end
        @(negedge clock);
    endtask

    task automatic test_saturation();
        do_reset();
        set_ctl(0, 1);
        repeat (300) @(negedge clock);
        #1;
        checks++;
        if (bus.stall_cnt !== 16'd300) begin errors++; $display("[TB] FAIL cnt_partial: got %0d want 300", bus.stall_cnt); end
        repeat (69700) @(negedge clock);
        #1;
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL cnt_saturate: got %h want ffff", bus.stall_cnt); end
        set_ctl(0, 0);
        @(negedge clock);
    endtask

    task automatic test_random();
        bit v, we, ld, cs, fl, mb, hz, stl;
        int rd, fwd, rs1, rs2;
        logic [4:0] exp_outs;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            rd  = $urandom_range(0, 7);
            we  = ($urandom_range(0, 3) != 0);
            ld  = $urandom_range(0, 1);
            cs  = ($urandom_range(0, 3) == 0);
            fwd = $urandom_range(0, 3);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            fl  = ($urandom_range(0, 7) == 0);
            mb  = ($urandom_range(0, 7) == 0);
            set_id(v, rd, we, ld, cs, fwd, rs1, rs2);
`ifndef MDU_STALL_EN
            bus.id_mdu = 1'($urandom_range(0, 1));
`endif
            set_ctl(fl, mb);
            #1;
            hz  = model_hazard(v, fl, fwd, rs1, rs2);
            stl = hz | mb;
            exp_outs = {stl, stl, hz & ~mb, mb, mb};
            checks++;
            if (outs() !== exp_outs) begin errors++; $display("[TB] FAIL rand_outs[%0d]: got %b want %b", n, outs(), exp_outs); end
            checks++;
            if (bus.stall_cnt !== 16'(m_cnt)) begin errors++; $display("[TB] FAIL rand_cnt[%0d]: got %0d want %0d", n, bus.stall_cnt, m_cnt); end
            if (!mb) begin
                m_pipe[2] = m_pipe[1];
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = (hz || fl || !v) ? make_ent(0, 0, 0, 0, 0) : make_ent(1, rd, we, ld, cs);
            end
            if (stl && m_cnt < 65535) m_cnt++;
            @(negedge clock);
        end
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_x0();
        test_mem_busy();
        test_flush();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
